fp_issue_ctrl: RTL
==================

Name: fp_issue_ctrl

Overview:
- Sequences one floating-point instruction at a time between the FP decoder and the FPNew unit.
- Launches FPU operations with a valid/ready handshake and waits for the result.
- Times fixed-latency register moves (FMV.X.S / FMV.S.X) with a counter.
- Retires each instruction with a single-cycle writeback to the FP or integer register file, and accumulates sticky exception flags (fflags).

Parameters:
- FLEN, 32, width of FP result and move data.
- MOVE_LAT, 2, cycles a move occupies before writeback (≥1).
- TIMEOUT, 64, max cycles in WAIT before an FPU timeout error (≥2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- dec_valid_i  in  1  decoded FP instruction present; held stable until dec_ready_o.
- dec_ready_o  out  1  retire pulse; instruction complete.
- dec_fpu_i  in  1  instruction needs FPU (decoder fpu_valid, not a move).
- dec_move_i  in  1  register move (fp_move_xs | fp_move_sx).
- dec_illegal_i  in  1  decoder flagged illegal.
- dec_fp_wr_i  in  1  writes FP register file.
- dec_int_wr_i  in  1  writes integer register file.
- dec_waddr_i  in  5  destination register.
- move_data_i  in  FLEN  source operand for moves.
- fpu_in_valid_o  out  1  FPU request valid.
- fpu_in_ready_i  in  1  FPU accepts request.
- fpu_out_valid_i  in  1  FPU result valid.
- fpu_out_ready_o  out  1  controller accepts result.
- fpu_result_i  in  FLEN  FPU result.
- fpu_status_i  in  5  FPU status {NV,DZ,OF,UF,NX}.
- fpu_flush_o  out  1  kill in-flight FPU op.
- flush_i  in  1  pipeline flush from core.
- fflags_clr_i  in  1  clear sticky flags.
- fp_we_o  out  1  FP regfile write enable.
- int_we_o  out  1  int regfile write enable.
- waddr_o  out  5  write address.
- wdata_o  out  FLEN  write data.
- fflags_o  out  5  sticky accrued flags.
- illegal_o  out  1  illegal-instruction pulse.
- timeout_o  out  1  sticky FPU timeout error.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset, asynchronous, active low: state=IDLE and every output 0. Captured waddr/result/flags registers are 0, and both counters are 0.
- States: IDLE, ISSUE, WAIT, MOVE, WB.
- The decode fields (kind bits and waddr) are captured on leaving IDLE. dec_* inputs are ignored outside IDLE.
- IDLE transitions, on dec_valid_i, evaluated in priority order:
  - dec_illegal_i → WB, no write, illegal_o=1 in WB.
  - dec_fpu_i → ISSUE.
  - dec_move_i → MOVE, counter=0.
  - otherwise (load/store, handled by the LSU) → WB, no write.
- ISSUE: fpu_in_valid_o=1 (registered, asserted the first cycle in ISSUE). It stays high until fpu_in_valid_o & fpu_in_ready_i, then → WAIT with the timeout counter cleared.
- WAIT: fpu_out_ready_o=1. When fpu_out_valid_i is high, capture fpu_result_i and fpu_status_i, then → WB.
  - fpu_out_ready_o is 0 in ISSUE, so a same-cycle result is held by the FPU until WAIT.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT-1 without a result: timeout_o←1 (sticky until reset), fpu_flush_o pulses, → WB with no write.
- MOVE: the counter increments each cycle. In the cycle where the counter reaches MOVE_LAT-1, capture move_data_i, then → WB. Minimum total latency is IDLE + MOVE_LAT + WB cycles.
- WB: lasts exactly one cycle, then → IDLE.
  - dec_ready_o=1.
  - int_we_o = captured int_wr. fp_we_o = captured fp_wr & ~captured int_wr (int wins if both are set).
  - waddr_o/wdata_o = captured values.
  - For FPU ops only: fflags_o |= captured status.
- Write enables are forced 0 for illegal, timeout, and load/store retirements.
- Minimum FPU latency: IDLE→ISSUE (1), in-handshake, WAIT≥1, WB (1).
- fflags_clr_i: fflags_o←0. If it coincides with a WB accumulate, fflags_o←captured status (clear, then accumulate).
- flush_i, any state except IDLE: next state=IDLE, no WB/dec_ready_o, no writes. fpu_flush_o=1 for that cycle if the state is ISSUE or WAIT. Flush in WB suppresses that cycle's writes and dec_ready_o. Flush in IDLE does nothing.
- wdata_o/waddr_o keep their last values when the enables are 0.

Test Plan:
- FADD: dec_fpu=1, fp_wr=1, waddr=5; FPU in_ready on 2nd ISSUE cycle; out_valid after 3 WAIT cycles with result 0x40400000, status 5'b00001 → one cycle fp_we_o=1, waddr_o=5, wdata_o=0x40400000, dec_ready_o=1, fflags_o=5'b00001.
- FMV.X.S with MOVE_LAT=2: dec_move=1, int_wr=1, waddr=10, move_data=0xDEADBEEF → int_we_o=1 exactly 3 cycles after acceptance, wdata_o=0xDEADBEEF, fp_we_o=0, fflags_o unchanged.
- Illegal: dec_valid=1 with dec_illegal=1 → next cycle illegal_o=1, dec_ready_o=1, no writes, fpu_in_valid_o never 1.
- Timeout with TIMEOUT=4: FPU accepts but never returns → after 4 WAIT cycles timeout_o=1, fpu_flush_o pulse, dec_ready_o=1, no write; timeout_o stays 1.
- Flush in WAIT: flush_i=1 → fpu_flush_o=1, state IDLE next cycle, no writes; a later out_valid is ignored.
- Flags: WB accumulates NX, then fflags_clr_i coincides with a WB carrying OF → fflags_o=5'b00100; async reset mid-ISSUE → all outputs 0 immediately.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// Floating-point issue controller: sequences one FP instruction at a time between the
// decoder and the FPU, times register moves, and retires it with a single writeback.
module fp_issue_ctrl #(
  parameter int unsigned FLEN     = 32,
  parameter int unsigned MOVE_LAT = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  logic            dec_fpu_i,
  input  logic            dec_move_i,
  input  logic            dec_illegal_i,
  input  logic            dec_fp_wr_i,
  input  logic            dec_int_wr_i,
  input  logic [4:0]      dec_waddr_i,
  input  logic [FLEN-1:0] move_data_i,
  output logic            fpu_in_valid_o,
  input  logic            fpu_in_ready_i,
  input  logic            fpu_out_valid_i,
  output logic            fpu_out_ready_o,
  input  logic [FLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  output logic            fpu_flush_o,
  input  logic            flush_i,
  input  logic            fflags_clr_i,
  output logic            fp_we_o,
  output logic            int_we_o,
  output logic [4:0]      waddr_o,
  output logic [FLEN-1:0] wdata_o,
  output logic [4:0]      fflags_o,
  output logic            illegal_o,
  output logic            timeout_o,
  output logic            busy_o
);

  localparam int unsigned MvW = (MOVE_LAT > 1) ? $clog2(MOVE_LAT) : 1;
  localparam int unsigned ToW = $clog2(TIMEOUT);
  localparam logic [MvW-1:0] MvLast = MvW'(MOVE_LAT - 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StMove, StWb} state_e;

  state_e state_q, state_d;

  logic            fpu_in_valid_q;
  logic            illegal_q, fp_wr_q, int_wr_q;
  logic [4:0]      waddr_q;
  logic [FLEN-1:0] res_q;
  logic [4:0]      status_q;
  logic            wr_en_q, acc_q;
  logic [MvW-1:0]  mv_cnt_q;
  logic [ToW-1:0]  to_cnt_q;
  logic [4:0]      fflags_q, fflags_d;
  logic            timeout_q;
  logic [4:0]      last_waddr_q;
  logic [FLEN-1:0] last_wdata_q;

  logic accept, in_hs, wait_done, wait_to, move_done, wb_live, wb_write;

  assign accept    = (state_q == StIdle) && dec_valid_i;
  assign in_hs     = (state_q == StIssue) && fpu_in_valid_q && fpu_in_ready_i;
  assign wait_done = (state_q == StWait) && fpu_out_valid_i;
  assign wait_to   = (state_q == StWait) && !fpu_out_valid_i && (to_cnt_q == ToLast);
  assign move_done = (state_q == StMove) && (mv_cnt_q == MvLast);
  assign wb_live   = (state_q == StWb) && !flush_i;
  assign wb_write  = wb_live && wr_en_q && (fp_wr_q || int_wr_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dec_valid_i) begin
          if (dec_illegal_i)   state_d = StWb;
          else if (dec_fpu_i)  state_d = StIssue;
          else if (dec_move_i) state_d = StMove;
          else                 state_d = StWb;
        end
      end
      StIssue: if (in_hs) state_d = StWait;
      StWait:  if (wait_done || wait_to) state_d = StWb;
      StMove:  if (move_done) state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A core flush abandons whatever is in progress, including a pending writeback.
    if (flush_i && (state_q != StIdle)) state_d = StIdle;
  end

  always_comb begin
    fflags_d = fflags_clr_i ? 5'd0 : fflags_q;
    if (wb_live && acc_q) fflags_d = fflags_d | status_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpu_in_valid_q <= 1'b0;
      illegal_q      <= 1'b0;
      fp_wr_q        <= 1'b0;
      int_wr_q       <= 1'b0;
      waddr_q        <= '0;
      res_q          <= '0;
      status_q       <= '0;
      wr_en_q        <= 1'b0;
      acc_q          <= 1'b0;
      mv_cnt_q       <= '0;
      to_cnt_q       <= '0;
      fflags_q       <= '0;
      timeout_q      <= 1'b0;
      last_waddr_q   <= '0;
      last_wdata_q   <= '0;
    end else begin
      fpu_in_valid_q <= (state_d == StIssue);
      fflags_q       <= fflags_d;
      if (accept) begin
        illegal_q <= dec_illegal_i;
        fp_wr_q   <= dec_fp_wr_i;
        int_wr_q  <= dec_int_wr_i;
        waddr_q   <= dec_waddr_i;
        wr_en_q   <= 1'b0;
        acc_q     <= 1'b0;
        mv_cnt_q  <= '0;
      end
      if (state_q == StMove) mv_cnt_q <= mv_cnt_q + MvW'(1);
      if (in_hs) begin
        to_cnt_q <= '0;
      end else if (state_q == StWait) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end
      if (wait_done) begin
        res_q    <= fpu_result_i;
        status_q <= fpu_status_i;
        wr_en_q  <= 1'b1;
        acc_q    <= 1'b1;
      end
      if (move_done) begin
        res_q   <= move_data_i;
        wr_en_q <= 1'b1;
      end
      if (wait_to && !flush_i) timeout_q <= 1'b1;
      if (wb_write) begin
        last_waddr_q <= waddr_q;
        last_wdata_q <= res_q;
      end
    end
  end

  always_comb begin
    dec_ready_o     = wb_live;
    illegal_o       = wb_live && illegal_q;
    int_we_o        = wb_write && int_wr_q;
    fp_we_o         = wb_write && fp_wr_q && !int_wr_q;
    // Write port shows the last committed value whenever no write is happening.
    waddr_o         = wb_write ? waddr_q : last_waddr_q;
    wdata_o         = wb_write ? res_q : last_wdata_q;
    fpu_in_valid_o  = fpu_in_valid_q;
    fpu_out_ready_o = (state_q == StWait);
    fpu_flush_o     = wait_to ||
                      (flush_i && ((state_q == StIssue) || (state_q == StWait)));
    busy_o          = (state_q != StIdle);
    fflags_o        = fflags_q;
    timeout_o       = timeout_q;
  end

endmodule
